// File: rtl/aes_dec_word_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : aes_dec_word_loader
//  Purpose  : Word-serial key/ciphertext loader and plaintext streamer wrapped
//             around a combinational AES-128 decryptor.
//  Options  : AES_LDR_BLKCNT_EN adds a saturating completed-block counter.
//  Revision : 1.0  initial release
// ============================================================================
module aes_dec_word_loader #(
    parameter int unsigned DEC_LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_wr,
    input  logic [1:0]   key_idx,
    input  logic [31:0]  key_word,
    output logic         key_err,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    output logic [127:0] dec_in,
    output logic [127:0] dec_key,
    input  logic [127:0] dec_out,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [31:0]  m_data,
    output logic         m_last,
`ifdef AES_LDR_BLKCNT_EN
    output logic [15:0]  blk_cnt,
`endif
    output logic         busy
);

    localparam logic [3:0] c_LAT_INIT = 4'(DEC_LAT - 1);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_WAIT    = 2'd1,
        ST_SEND    = 2'd2
    } state_t;

    state_t        state_q,   state_d;
    logic [1:0]    cnt_q,     cnt_d;
    logic [3:0]    lat_q,     lat_d;
    logic [127:0]  key_q,     key_d;
    logic [127:0]  ct_q,      ct_d;
    logic [127:0]  pt_q,      pt_d;
    logic          s_ready_q, s_ready_d;
    logic          m_valid_q, m_valid_d;
    logic          m_last_q,  m_last_d;
    logic [31:0]   m_data_q,  m_data_d;
    logic          key_err_q, key_err_d;
    logic          busy_q,    busy_d;
`ifdef AES_LDR_BLKCNT_EN
    logic [15:0]   blk_cnt_q, blk_cnt_d;
`endif

    logic w_s_acc;
    logic w_m_acc;

    // Word i of a 128-bit vector lives at [127-32i -: 32].
    function automatic logic [31:0] get_word(input logic [127:0] v, input logic [1:0] idx);
        logic [31:0] r;
        case (idx)
            2'd0:    r = v[127:96];
            2'd1:    r = v[95:64];
            2'd2:    r = v[63:32];
            default: r = v[31:0];
        endcase
        return r;
    endfunction

    function automatic logic [127:0] put_word(input logic [127:0] v, input logic [1:0] idx,
                                              input logic [31:0] w);
        logic [127:0] r;
        r = v;
        case (idx)
            2'd0:    r[127:96] = w;
            2'd1:    r[95:64]  = w;
            2'd2:    r[63:32]  = w;
            default: r[31:0]   = w;
        endcase
        return r;
    endfunction

    assign w_s_acc = s_valid & s_ready_q;
    assign w_m_acc = m_valid_q & m_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lat_d     = lat_q;
        key_d     = key_q;
        ct_d      = ct_q;
        pt_d      = pt_q;
        s_ready_d = s_ready_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_data_d  = m_data_q;
        key_err_d = 1'b0;
        busy_d    = busy_q;
`ifdef AES_LDR_BLKCNT_EN
        blk_cnt_d = blk_cnt_q;
`endif

        // The key may only change before the first ciphertext word of a block.
        if (key_wr) begin
            if (state_q == ST_COLLECT && cnt_q == 2'd0) begin
                key_d = put_word(key_q, key_idx, key_word);
            end else begin
                key_err_d = 1'b1;
            end
        end

        case (state_q)
            ST_COLLECT: begin
                if (w_s_acc) begin
                    ct_d  = {ct_q[95:0], s_data};
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d   = ST_WAIT;
                        lat_d     = c_LAT_INIT;
                        s_ready_d = 1'b0;
                        busy_d    = 1'b1;
                    end
                end
            end

            ST_WAIT: begin
                if (lat_q == 4'd0) begin
                    pt_d      = dec_out;
                    state_d   = ST_SEND;
                    m_valid_d = 1'b1;
                    m_data_d  = dec_out[127:96];
                    m_last_d  = 1'b0;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end

            ST_SEND: begin
                if (w_m_acc) begin
                    if (cnt_q == 2'd3) begin
                        state_d   = ST_COLLECT;
                        cnt_d     = 2'd0;
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        s_ready_d = 1'b1;
                        busy_d    = 1'b0;
`ifdef AES_LDR_BLKCNT_EN
                        if (blk_cnt_q != 16'hFFFF) begin
                            blk_cnt_d = blk_cnt_q + 16'd1;
                        end
`endif
                    end else begin
                        cnt_d    = cnt_q + 2'd1;
                        m_data_d = get_word(pt_q, cnt_q + 2'd1);
                        m_last_d = (cnt_q == 2'd2);
                    end
                end
            end

            default: begin
                state_d   = ST_COLLECT;
                cnt_d     = 2'd0;
                s_ready_d = 1'b1;
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_COLLECT;
            cnt_q     <= 2'd0;
            lat_q     <= 4'd0;
            key_q     <= '0;
            ct_q      <= '0;
            pt_q      <= '0;
            s_ready_q <= 1'b1;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            key_err_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef AES_LDR_BLKCNT_EN
            blk_cnt_q <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lat_q     <= lat_d;
            key_q     <= key_d;
            ct_q      <= ct_d;
            pt_q      <= pt_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_data_q  <= m_data_d;
            key_err_q <= key_err_d;
            busy_q    <= busy_d;
`ifdef AES_LDR_BLKCNT_EN
            blk_cnt_q <= blk_cnt_d;
`endif
        end
    end

    assign dec_in  = ct_q;
    assign dec_key = key_q;
    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign key_err = key_err_q;
    assign busy    = busy_q;
`ifdef AES_LDR_BLKCNT_EN
    assign blk_cnt = blk_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aes_dec_word_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_aes_dec_word_loader
//  Purpose  : Directed plus randomized bench for aes_dec_word_loader with a
//             latency-aware stand-in decryptor (AES_LDR_BLKCNT_EN optional).
//  Revision : 1.0  initial release
// ============================================================================
module tb_aes_dec_word_loader;

    localparam int DEC_LAT = 2;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_wr;
    logic [1:0]   key_idx;
    logic [31:0]  key_word;
    logic         key_err;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic [127:0] dec_in;
    logic [127:0] dec_key;
    logic [127:0] dec_out;
    logic         m_valid;
    logic         m_ready;
    logic [31:0]  m_data;
    logic         m_last;
    logic         busy;
`ifdef AES_LDR_BLKCNT_EN
    logic [15:0]  blk_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int blocks_done = 0;
    logic [31:0] ref_key [4];

    always #5 clk = ~clk;

    aes_dec_word_loader #(.DEC_LAT(DEC_LAT)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_wr   (key_wr),
        .key_idx  (key_idx),
        .key_word (key_word),
        .key_err  (key_err),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .dec_in   (dec_in),
        .dec_key  (dec_key),
        .dec_out  (dec_out),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
`ifdef AES_LDR_BLKCNT_EN
        .blk_cnt  (blk_cnt),
`endif
        .busy     (busy)
    );

    // Stand-in decryptor: the FIPS-197 C.1 pair maps to its true plaintext,
    // anything else to a keyed scramble; output is corrupted until inputs have
    // been stable for DEC_LAT cycles.
    function automatic logic [127:0] toy_dec(input logic [127:0] ct, input logic [127:0] k);
        if (ct == CT_C1 && k == KEY_C1) return PT_C1;
        return ct ^ {k[95:0], k[127:96]} ^ 128'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3_9696_6969;
    endfunction

    logic [255:0] run_val = '0;
    int           run_len = 0;
    int           held;

    always @(posedge clk) begin
        if ({dec_in, dec_key} === run_val) run_len <= run_len + 1;
        else                               run_len <= 1;
        run_val <= {dec_in, dec_key};
    end

    always_comb begin
        held = ({dec_in, dec_key} === run_val) ? run_len + 1 : 1;
        dec_out = (held >= DEC_LAT) ? toy_dec(dec_in, dec_key) : ~toy_dec(dec_in, dec_key);
    end

    function automatic logic [127:0] key_vec();
        return {ref_key[0], ref_key[1], ref_key[2], ref_key[3]};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) ref_key[i] = 32'd0;
        blocks_done = 0;
        chk("rst_s_ready", 128'(s_ready), 128'(1));
        chk("rst_m_valid", 128'(m_valid), 128'(0));
        chk("rst_m_last",  128'(m_last),  128'(0));
        chk("rst_key_err", 128'(key_err), 128'(0));
        chk("rst_busy",    128'(busy),    128'(0));
        chk("rst_dec_key", dec_key, key_vec());
        chk("rst_dec_in",  dec_in,  128'(0));
`ifdef AES_LDR_BLKCNT_EN
        chk("rst_blk_cnt", 128'(blk_cnt), 128'(0));
`endif
    endtask

    task automatic write_key(input logic [1:0] idx, input logic [31:0] w);
        key_wr = 1'b1; key_idx = idx; key_word = w;
        @(negedge clk);
        key_wr = 1'b0;
        ref_key[idx] = w;
        chk("key_err_idle", 128'(key_err), 128'(0));
    endtask

    task automatic send_ct(input logic [31:0] w, input bit keep);
        int n;
        s_valid = 1'b1; s_data = w; n = 0;
        while (s_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            total++; bad++;
            $error("FAIL s_ready_timeout: observed=%0d expected=<64", n);
        end
        @(negedge clk);
        if (!keep) s_valid = 1'b0;
    endtask

    task automatic send_block(input logic [127:0] ct, input bit keep);
        for (int i = 0; i < 4; i++) send_ct(ct[127-32*i -: 32], keep);
    endtask

    task automatic recv_block(input logic [127:0] exp, input int bp_word, input int bp_len,
                              input bit kerr);
        int k;
        logic [127:0] key_before;
        logic [31:0]  ew;
        key_before = key_vec();
        chk("dec_key", dec_key, key_before);
        k = 1;
        while (m_valid !== 1'b1 && k < 64) begin
            if (kerr && k == 2) chk("key_err_pulse", 128'(key_err), 128'(1));
            key_wr = 1'b0;
            if (kerr && k == 1) begin
                key_wr = 1'b1; key_idx = 2'd0; key_word = $urandom;
            end
            chk("busy_wait", 128'(busy), 128'(1));
            chk("s_ready_wait", 128'(s_ready), 128'(0));
            @(negedge clk);
            k++;
        end
        key_wr = 1'b0;
        if (kerr) chk("key_err_once", 128'(key_err), 128'(0));
        chk("first_valid_lat", 128'(k), 128'(DEC_LAT + 1));
        chk("dec_key_hold", dec_key, key_before);
        for (int i = 0; i < 4; i++) begin
            ew = exp[127-32*i -: 32];
            if (i == bp_word) begin
                m_ready = 1'b0;
                for (int c = 0; c < bp_len; c++) begin
                    chk("bp_m_valid", 128'(m_valid), 128'(1));
                    chk("bp_m_data",  128'(m_data),  128'(ew));
                    chk("bp_m_last",  128'(m_last),  128'(i == 3));
                    @(negedge clk);
                end
            end
            m_ready = 1'b1;
            chk("m_valid", 128'(m_valid), 128'(1));
            chk("m_data",  128'(m_data),  128'(ew));
            chk("m_last",  128'(m_last),  128'(i == 3));
            chk("s_ready_send", 128'(s_ready), 128'(0));
            @(negedge clk);
        end
        m_ready = 1'b0;
        blocks_done++;
        chk("done_m_valid", 128'(m_valid), 128'(0));
        chk("done_s_ready", 128'(s_ready), 128'(1));
        chk("done_busy",    128'(busy),    128'(0));
`ifdef AES_LDR_BLKCNT_EN
        chk("blk_cnt", 128'(blk_cnt), 128'(blocks_done));
`endif
    endtask

    initial begin
        logic [127:0] ct;
        logic [31:0]  kw;
        logic [1:0]   ki;
        rst_n = 1'b0; key_wr = 1'b0; key_idx = 2'd0; key_word = 32'd0;
        s_valid = 1'b0; s_data = 32'd0; m_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // FIPS-197 C.1 vector
        for (int i = 0; i < 4; i++) write_key(2'(i), KEY_C1[127-32*i -: 32]);
        chk("dec_key_loaded", dec_key, KEY_C1);
        send_block(CT_C1, 1'b0);
        recv_block(PT_C1, 4, 0, 1'b0);

        // Backpressure at word 2 for 5 cycles
        send_block(CT_C1, 1'b0);
        recv_block(PT_C1, 2, 5, 1'b0);

        // Key write while busy
        send_block(CT_C1, 1'b0);
        recv_block(PT_C1, 4, 0, 1'b1);

        // Reset after two ciphertext words, then a fresh block
        send_ct(CT_C1[127:96], 1'b0);
        send_ct(CT_C1[95:64], 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) write_key(2'(i), KEY_C1[127-32*i -: 32]);
        send_block(CT_C1, 1'b0);
        recv_block(PT_C1, 4, 0, 1'b0);

        // Back-to-back blocks with s_valid held high across the boundary
        ct = {$urandom, $urandom, $urandom, $urandom};
        send_block(CT_C1, 1'b1);
        s_data = ct[127:96];
        recv_block(PT_C1, 4, 0, 1'b0);
        send_ct(ct[127:96], 1'b1);
        send_ct(ct[95:64], 1'b1);
        send_ct(ct[63:32], 1'b1);
        send_ct(ct[31:0], 1'b0);
        recv_block(toy_dec(ct, key_vec()), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);

        // Key write coinciding with the first ciphertext accept
        ct = {$urandom, $urandom, $urandom, $urandom};
        kw = $urandom;
        key_wr = 1'b1; key_idx = 2'd3; key_word = kw;
        s_valid = 1'b1; s_data = ct[127:96];
        @(negedge clk);
        key_wr = 1'b0; s_valid = 1'b0;
        ref_key[3] = kw;
        chk("key_err_first", 128'(key_err), 128'(0));
        send_ct(ct[95:64], 1'b0);
        send_ct(ct[63:32], 1'b0);
        send_ct(ct[31:0], 1'b0);
        recv_block(toy_dec(ct, key_vec()), 4, 0, 1'b0);

        // Randomized blocks, repeated key indices exercise last-write-wins
        for (int b = 0; b < 6; b++) begin
            for (int w = 0; w < 6; w++) begin
                ki = 2'($urandom_range(0, 3));
                kw = $urandom;
                write_key(ki, kw);
            end
            chk("dec_key_rand", dec_key, key_vec());
            ct = {$urandom, $urandom, $urandom, $urandom};
            send_block(ct, 1'b0);
            recv_block(toy_dec(ct, key_vec()), $urandom_range(0, 4), $urandom_range(0, 4), 1'b0);
        end

        do_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
